mem_addr_sequencer: RTL and testbench

- Parametrised successor to the instruction-or-data memory address selector.
- Selects one of N_SRC address sources, e.g. PC, ALUOut and the exception-vector addresses, and checks alignment against the access size.
- Registers the chosen address and holds it stable, with a write strobe, for the fixed memory latency, then pulses done.
- Sits between the control unit and the memory in the multicycle datapath.

---
 rtl/mem_addr_sequencer.sv | 134 +++++++++++++
 tb/tb_mem_addr_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_addr_sequencer.sv
// Memory address sequencer: picks one of N_SRC address sources, checks that
// the address is aligned for the access size, and holds the registered address
// and write strobe for LATENCY cycles. It then pulses done.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; addr_out holds the last latched address
// ACCESS | address and strobe held for the memory; counter runs down
// DONE   | one-cycle completion; start is ignored here
module mem_addr_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int N_SRC   = 4,
  parameter int SEL_W   = 2,
  parameter int LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [SEL_W-1:0]        sel,
  input  logic [N_SRC*ADDR_W-1:0] src_flat,
  input  logic [1:0]              size,
  input  logic                    we,
  output logic [ADDR_W-1:0]       addr_out,
  output logic                    mem_we,
  output logic                    busy,
  output logic                    done,
  output logic                    misaligned,
  output logic                    invalid_sel
);

  localparam int CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam logic [SEL_W:0] N_SRC_EXT = (SEL_W + 1)'(N_SRC);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [ADDR_W-1:0]  addr_q, addr_nxt;
  logic               we_q, we_nxt;
  logic               mis_q, mis_nxt;
  logic               inv_q, inv_nxt;
  logic [ADDR_W-1:0]  src_sel;
  logic               sel_bad;
  logic               addr_ok;

  assign sel_bad = ({1'b0, sel} >= N_SRC_EXT);

  // Plain index mux over the sources. An out-of-range sel reads as zero, but
  // that value is never used because sel_bad blocks the access first.
  always_comb begin
    src_sel = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (sel == SEL_W'(k)) src_sel = src_flat[k*ADDR_W +: ADDR_W];
    end
  end

  // Alignment check for the selected source against the access size.
  always_comb begin
    addr_ok = 1'b0;
    case (size)
      2'b00:   addr_ok = (src_sel[1:0] == 2'b00);
      2'b01:   addr_ok = (src_sel[0] == 1'b0);
      2'b10:   addr_ok = 1'b1;
      default: addr_ok = 1'b0;
    endcase
  end

  // Next-state logic. It also computes the latched address, strobe and counter.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    addr_nxt  = addr_q;
    we_nxt    = we_q;
    mis_nxt   = 1'b0;
    inv_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (sel_bad) begin
            inv_nxt = 1'b1;
          end else if (!addr_ok) begin
            mis_nxt = 1'b1;
          end else begin
            addr_nxt  = src_sel;
            we_nxt    = we;
            cnt_nxt   = CNT_W'(LATENCY);
            state_nxt = ACCESS;
          end
        end
      end
      ACCESS: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers, with a synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      we_q   <= 1'b0;
      mis_q  <= 1'b0;
      inv_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      addr_q <= addr_nxt;
      we_q   <= we_nxt;
      mis_q  <= mis_nxt;
      inv_q  <= inv_nxt;
    end
  end

  assign addr_out    = addr_q;
  assign busy        = (state != IDLE);
  assign mem_we      = (state == ACCESS) && we_q;
  assign done        = (state == DONE);
  assign misaligned  = mis_q;
  assign invalid_sel = inv_q;

endmodule

// File: tb/tb_mem_addr_sequencer.sv
// Bench for mem_addr_sequencer (N_SRC=3 build, so sel=3 is illegal).
// The reference model tracks accesses by the edge index at which they were
// accepted. It derives every expected output from that distance.
module tb_mem_addr_sequencer;

  localparam int AW  = 32;
  localparam int NS  = 3;
  localparam int SW  = 2;
  localparam int LAT = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [SW-1:0]      sel;
  logic [NS*AW-1:0]   src_flat;
  logic [1:0]         size;
  logic               we;
  logic [AW-1:0]      addr_out;
  logic               mem_we;
  logic               busy;
  logic               done;
  logic               misaligned;
  logic               invalid_sel;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int           edge_n = 0;
  int           acc_t  = -1;
  logic [31:0]  m_addr = '0;
  logic         m_we   = 1'b0;
  logic         m_mis  = 1'b0;
  logic         m_inv  = 1'b0;

  mem_addr_sequencer #(
    .ADDR_W(AW), .N_SRC(NS), .SEL_W(SW), .LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .sel(sel), .src_flat(src_flat),
    .size(size), .we(we), .addr_out(addr_out), .mem_we(mem_we), .busy(busy),
    .done(done), .misaligned(misaligned), .invalid_sel(invalid_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at edge %0d", tag, got, exp, edge_n);
    end
  endtask

  function automatic logic is_aligned(input logic [31:0] a, input logic [1:0] s);
    if (s == 2'b00) return a[1:0] == 2'b00;
    if (s == 2'b01) return a[0] == 1'b0;
    if (s == 2'b10) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] src_of(input int k);
    return src_flat[k*AW +: AW];
  endfunction

  // Advance one clock edge, update the model, then compare all outputs.
  task automatic tick();
    int d;
    logic e_busy, e_we, e_done;
    @(posedge clk);
    edge_n++;
    m_mis = 1'b0;
    m_inv = 1'b0;
    if (reset) begin
      acc_t  = -1;
      m_addr = '0;
      m_we   = 1'b0;
    end else if (acc_t >= 0 && edge_n <= acc_t + LAT + 1) begin
      // an access or its done cycle is in progress; start is ignored
    end else if (start) begin
      if (int'(sel) >= NS) m_inv = 1'b1;
      else if (!is_aligned(src_of(int'(sel)), size)) m_mis = 1'b1;
      else begin
        acc_t  = edge_n;
        m_addr = src_of(int'(sel));
        m_we   = we;
      end
    end
    #1;
    d      = edge_n - acc_t;
    e_busy = (acc_t >= 0) && (d <= LAT);
    e_we   = (acc_t >= 0) && (d < LAT) && m_we;
    e_done = (acc_t >= 0) && (d == LAT);
    chk("addr_out",    addr_out,    m_addr);
    chk("busy",        32'(busy),        32'(e_busy));
    chk("mem_we",      32'(mem_we),      32'(e_we));
    chk("done",        32'(done),        32'(e_done));
    chk("misaligned",  32'(misaligned),  32'(m_mis));
    chk("invalid_sel", 32'(invalid_sel), 32'(m_inv));
  endtask

  task automatic set_src(input int k, input logic [31:0] v);
    src_flat[k*AW +: AW] = v;
  endtask

  task automatic req(input logic [SW-1:0] s, input logic [1:0] sz, input logic w);
    sel = s; size = sz; we = w; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sel = '0; src_flat = '0; size = 2'b00; we = 1'b0;
    tick(); tick();
    chk("rst_addr", addr_out, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    tick();

    // Word read from PC.
    set_src(0, 32'h0000_0040);
    req(2'd0, 2'b00, 1'b0);
    chk("rd_addr", addr_out, 32'h40);
    chk("rd_busy", 32'(busy), 32'h1);
    tick();
    tick();
    chk("rd_done", 32'(done), 32'h1);
    tick();
    chk("rd_idle", 32'(busy), 32'h0);

    // Write from ALUOut. The source changes during ACCESS.
    set_src(1, 32'h0000_1000);
    req(2'd1, 2'b00, 1'b1);
    chk("wr_we", 32'(mem_we), 32'h1);
    set_src(1, 32'hFFFF_FFFC);
    tick();
    chk("wr_hold", addr_out, 32'h1000);
    tick();
    chk("wr_done_we", 32'(mem_we), 32'h0);
    tick();

    // Alignment cases.
    set_src(0, 32'h0000_0042);
    req(2'd0, 2'b00, 1'b0);
    chk("mis_word", 32'(misaligned), 32'h1);
    chk("mis_keep", addr_out, 32'h1000);
    tick();
    req(2'd0, 2'b01, 1'b0);
    chk("half_ok", addr_out, 32'h42);
    repeat (3) tick();
    set_src(0, 32'h0000_0043);
    req(2'd0, 2'b01, 1'b0);
    chk("mis_half", 32'(misaligned), 32'h1);
    tick();
    set_src(0, 32'h0000_0000);
    req(2'd0, 2'b11, 1'b0);
    chk("mis_rsv", 32'(misaligned), 32'h1);
    tick();

    // An illegal select raises only invalid_sel.
    req(2'd3, 2'b11, 1'b0);
    chk("inv_sel", 32'(invalid_sel), 32'h1);
    chk("inv_nomis", 32'(misaligned), 32'h0);
    tick();

    // With start held high, accesses repeat every LAT+2 cycles.
    set_src(2, 32'h0000_00FD);
    sel = 2'd2; size = 2'b10; we = 1'b0; start = 1'b1;
    repeat (12) tick();
    start = 1'b0;
    repeat (3) tick();

    // Reset in the second ACCESS cycle of a write.
    set_src(1, 32'h0000_2000);
    req(2'd1, 2'b00, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    chk("rst_mid_addr", addr_out, 32'h0);
    chk("rst_mid_we", 32'(mem_we), 32'h0);
    reset = 1'b0;
    tick();
    req(2'd1, 2'b00, 1'b0);
    chk("post_rst", addr_out, 32'h2000);
    repeat (3) tick();

    // Randomised traffic.
    for (int i = 0; i < 2000; i++) begin
      for (int k = 0; k < NS; k++) begin
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(1, 0) == 1) v[1:0] = 2'b00;
        set_src(k, v);
      end
      sel   = SW'($urandom_range(3, 0));
      size  = 2'($urandom_range(3, 0));
      we    = 1'($urandom_range(1, 0));
      start = ($urandom_range(9, 0) < 6);
      reset = ($urandom_range(99, 0) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
